// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with selectable registered or first-word-fall-through read,
// fill count, programmable almost-full/almost-empty thresholds and sticky error flags.
module fifo_sync_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_fill,
    input  logic                  i_clr_err,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AFULL_T  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_T = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    if (DATA_WIDTH < 1 || ADDR_WIDTH < 1 || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1 || (FWFT != 0 && FWFT != 1))
    begin : g_param_err
        $error("fifo_sync_param: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rd_ok_s;
    logic                  wr_ok_s;

    // Accept decisions, next pointers/fill and next registered flags
    always_comb begin
        rd_ok_s = i_rd && !empty_q;
        // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
        wr_ok_s = i_wr && (!full_q || rd_ok_s);

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fill_d = fill_q;

        if (wr_ok_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_ok_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end

        case ({wr_ok_s, rd_ok_s})
            2'b10:   fill_d = fill_q + PTR_ONE;
            2'b01:   fill_d = fill_q - PTR_ONE;
            default: fill_d = fill_q;
        endcase

        full_d   = (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]) &&
                   (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]);
        empty_d  = (wptr_d == rptr_d);
        afull_d  = (fill_d >= AFULL_T);
        aempty_d = (fill_d <= AEMPTY_T);

        if (i_wr && !wr_ok_s) begin
            ovf_d = 1'b1;
        end else if (i_clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (i_rd && !rd_ok_s) begin
            udf_d = 1'b1;
        end else if (i_clr_err) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // Pointer, fill, status and error registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr_q   <= {(ADDR_WIDTH + 1){1'b0}};
            rptr_q   <= {(ADDR_WIDTH + 1){1'b0}};
            fill_q   <= {(ADDR_WIDTH + 1){1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            fill_q   <= fill_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array, deliberately without reset
    always_ff @(posedge i_clk) begin
        if (wr_ok_s) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= i_wdata;
        end
    end

    if (FWFT == 1) begin : g_fwft
        // head is visible directly; forced to zero while empty so it stays stable
        assign o_rdata = empty_q ? {DATA_WIDTH{1'b0}} : mem_q[rptr_q[ADDR_WIDTH-1:0]];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

        // Load the popped word, hold otherwise
        always_comb begin
            if (rd_ok_s) begin
                rdata_d = mem_q[rptr_q[ADDR_WIDTH-1:0]];
            end else begin
                rdata_d = rdata_q;
            end
        end

        // Registered read data
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                rdata_q <= {DATA_WIDTH{1'b0}};
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign o_rdata = rdata_q;
    end

    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_fill         = fill_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

    fifo_sync_param_chk #(.ADDR_WIDTH(ADDR_WIDTH)) u_chk (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_wptr  (wptr_q),
        .i_rptr  (rptr_q),
        .i_fill  (fill_q),
        .i_full  (full_q),
        .i_empty (empty_q)
    );

endmodule

// Structural invariants of the FIFO occupancy bookkeeping.
module fifo_sync_param_chk #(
    parameter int ADDR_WIDTH = 4
) (
    input logic                i_clk,
    input logic                i_rstn,
    input logic [ADDR_WIDTH:0] i_wptr,
    input logic [ADDR_WIDTH:0] i_rptr,
    input logic [ADDR_WIDTH:0] i_fill,
    input logic                i_full,
    input logic                i_empty
);

    logic [ADDR_WIDTH:0] diff_s;
    assign diff_s = i_wptr - i_rptr;

    a_fill_matches_ptrs: assert property (@(posedge i_clk) disable iff (!i_rstn)
        i_fill == diff_s);

    a_not_full_and_empty: assert property (@(posedge i_clk) disable iff (!i_rstn)
        !(i_full && i_empty));

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised scoreboard bench: a registered-read and a FWFT instance share stimulus and are
// compared against a queue-based reference model of the FIFO.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rstn;
    logic       wr, rd, clr;
    logic [7:0] wdata;
    logic [7:0] rdata0, rdata1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0] fill0, fill1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         fill;
        logic       ovf;
        logic       udf;
        logic [7:0] rd0;
        logic [7:0] rd1;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_rd0 = 8'h00;

    always #5 clk = ~clk;

    fifo_sync_param #(.FWFT(0)) u_dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_wr(wr), .i_wdata(wdata), .i_rd(rd),
        .o_rdata(rdata0), .o_full(full0), .o_empty(empty0), .o_almost_full(af0),
        .o_almost_empty(ae0), .o_fill(fill0), .i_clr_err(clr),
        .o_overflow(ovf0), .o_underflow(udf0)
    );

    fifo_sync_param #(.FWFT(1)) u_dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_wr(wr), .i_wdata(wdata), .i_rd(rd),
        .o_rdata(rdata1), .o_full(full1), .o_empty(empty1), .o_almost_full(af1),
        .o_almost_empty(ae1), .o_fill(fill1), .i_clr_err(clr),
        .o_overflow(ovf1), .o_underflow(udf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.fill = model_q.size();
        e.ovf  = m_ovf;
        e.udf  = m_udf;
        e.rd0  = m_rd0;
        e.rd1  = (model_q.size() > 0) ? model_q[0] : 8'h00;
        return e;
    endfunction

    task automatic compare_all(input exp_t e);
        check("dut0.fill",   32'(fill0),  32'(e.fill));
        check("dut0.full",   32'(full0),  32'(e.fill == 16));
        check("dut0.empty",  32'(empty0), 32'(e.fill == 0));
        check("dut0.afull",  32'(af0),    32'(e.fill >= 14));
        check("dut0.aempty", 32'(ae0),    32'(e.fill <= 2));
        check("dut0.ovf",    32'(ovf0),   32'(e.ovf));
        check("dut0.udf",    32'(udf0),   32'(e.udf));
        check("dut0.rdata",  32'(rdata0), 32'(e.rd0));
        check("dut1.fill",   32'(fill1),  32'(e.fill));
        check("dut1.full",   32'(full1),  32'(e.fill == 16));
        check("dut1.empty",  32'(empty1), 32'(e.fill == 0));
        check("dut1.ovf",    32'(ovf1),   32'(e.ovf));
        check("dut1.udf",    32'(udf1),   32'(e.udf));
        check("dut1.rdata",  32'(rdata1), 32'(e.rd1));
    endtask

    // Monitor: every edge's expected outcome is checked on the following falling edge
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare_all(e);
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit rd_ok, wr_ok;
        int n;
        wr = w; wdata = d; rd = r; clr = c;
        n = model_q.size();
        rd_ok = r && (n > 0);
        wr_ok = w && ((n < 16) || rd_ok);
        @(posedge clk);
        if (rd_ok) m_rd0 = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        if (w && !wr_ok) m_ovf = 1'b1;
        else if (c)      m_ovf = 1'b0;
        if (r && !rd_ok) m_udf = 1'b1;
        else if (c)      m_udf = 1'b0;
        exp_q.push_back(snap());
        @(negedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_rd0 = 8'h00;
    endtask

    initial begin
        int pw, pr;
        rstn = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0; wdata = 8'h00;
        @(negedge clk);
        #1;
        compare_all(snap());
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        step(1'b1, 8'h77, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        for (int ph = 0; ph < 4; ph++) begin
            pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
            pr = (ph == 0) ? 30 : (ph == 1) ? 80 : 50;
            for (int i = 0; i < 80; i++) begin
                step(1'($urandom_range(0, 99) < pw), 8'($urandom),
                     1'($urandom_range(0, 99) < pr), 1'($urandom_range(0, 15) == 0));
            end
        end

        while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        model_reset();
        compare_all(snap());
        #1;
        rstn = 1'b1;
        @(negedge clk);
        #1;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
